// File: rtl/reg_bus_arbiter_pkg.sv
// Shared definitions for the peripheral register-bus arbiter: FSM states,
// register ids of the i2c/uart/counter register file, and the timeout fill value.
package reg_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [15:0] ID_I2C_DATA   = 16'd1;
  localparam logic [15:0] ID_I2C_STATUS = 16'd2;
  localparam logic [15:0] ID_UART_DATA  = 16'd3;
  localparam logic [15:0] ID_TXCOUNT    = 16'd4;
  localparam logic [15:0] ID_RXCOUNT    = 16'd5;
  localparam logic [15:0] ID_BUSY       = 16'd8;
  localparam logic [15:0] ID_SYNC       = 16'd9;

  localparam logic [15:0] DEAD_DATA = 16'hDEAD;

endpackage

// File: rtl/reg_bus_arbiter_rr_arb2.sv
// Two-way round-robin grant. last_q remembers the last served port; on a tie
// the other port wins. Reset sets last_q to port 1 so port 0 wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update_en,
  input  logic       update_port,
  output logic       any,
  output logic       gnt
);

  logic last_q, last_d;

  // NOTE: every output of a combinational block gets a value on every path, so no latch is inferred.
  always_comb begin
    any    = |req;
    gnt    = (&req) ? ~last_q : req[1];
    last_d = update_en ? update_port : last_q;
  end

  // NOTE: clocked state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing the peripheral register bus between the soft CPU
// (port 0) and the UART command interpreter (port 1). Optional bus_ready
// timeout is compiled in with `define REG_BUS_TIMEOUT_EN.
module reg_bus_arbiter
  import reg_bus_arbiter_pkg::*;
#(
  parameter int             DW      = 16,
  parameter int             IW      = 16,
  parameter logic [IW-1:0]  IDLE_ID = '0,
  parameter int             TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  input  logic          req0_write,
  input  logic [IW-1:0] req0_id,
  input  logic [DW-1:0] req0_wdata,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1_valid,
  input  logic          req1_write,
  input  logic [IW-1:0] req1_id,
  input  logic [DW-1:0] req1_wdata,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic [IW-1:0] bus_id,
  output logic          bus_read,
  output logic          bus_write,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  input  logic          bus_ready,
  output logic          busy,
  output logic          err
);

  state_e        state_q, state_d;
  logic          port_q, port_d;
  logic          write_q, write_d;
  logic [IW-1:0] bus_id_q, bus_id_d;
  logic          bus_read_q, bus_read_d;
  logic          bus_write_q, bus_write_d;
  logic [DW-1:0] bus_wdata_q, bus_wdata_d;
  logic          busy_q, busy_d;
  logic          ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [DW-1:0] rsp_data;
  logic          arb_any, arb_gnt, arb_update;
  logic          sel_write;
  logic          timeout_hit;
  logic          err_d;

  rr_arb2 u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         ({req1_valid, req0_valid}),
    .update_en   (arb_update),
    .update_port (port_q),
    .any         (arb_any),
    .gnt         (arb_gnt)
  );

  assign sel_write = arb_gnt ? req1_write : req0_write;

`ifdef REG_BUS_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q;

  always_comb begin
    timeout_hit = (state_q == ST_ACCESS) && (cnt_q == CW'(TIMEOUT - 1));
    if (state_q != ST_ACCESS) cnt_d = '0;
    else                      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    write_d     = write_q;
    bus_id_d    = bus_id_q;
    bus_read_d  = bus_read_q;
    bus_write_d = 1'b0;
    bus_wdata_d = bus_wdata_q;
    busy_d      = busy_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    rdata0_d    = '0;
    rdata1_d    = '0;
    err_d       = 1'b0;
    arb_update  = 1'b0;
    rsp_data    = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          state_d     = ST_ACCESS;
          port_d      = arb_gnt;
          write_d     = sel_write;
          bus_id_d    = arb_gnt ? req1_id : req0_id;
          bus_read_d  = ~sel_write;
          bus_write_d = sel_write;
          bus_wdata_d = sel_write ? (arb_gnt ? req1_wdata : req0_wdata) : '0;
          busy_d      = 1'b1;
        end
      end
      ST_ACCESS: begin
        // A real bus_ready takes priority over a timeout landing in the same cycle.
        if (bus_ready || timeout_hit) begin
          if (!bus_ready)    rsp_data = DW'(DEAD_DATA);
          else if (!write_q) rsp_data = bus_rdata;
          state_d     = ST_RESP;
          ack0_d      = ~port_q;
          ack1_d      = port_q;
          rdata0_d    = port_q ? '0 : rsp_data;
          rdata1_d    = port_q ? rsp_data : '0;
          err_d       = ~bus_ready;
          bus_id_d    = IDLE_ID;
          bus_read_d  = 1'b0;
          bus_wdata_d = '0;
        end
      end
      ST_RESP: begin
        state_d    = ST_IDLE;
        busy_d     = 1'b0;
        arb_update = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      port_q      <= 1'b0;
      write_q     <= 1'b0;
      bus_id_q    <= IDLE_ID;
      bus_read_q  <= 1'b0;
      bus_write_q <= 1'b0;
      bus_wdata_q <= '0;
      busy_q      <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      write_q     <= write_d;
      bus_id_q    <= bus_id_d;
      bus_read_q  <= bus_read_d;
      bus_write_q <= bus_write_d;
      bus_wdata_q <= bus_wdata_d;
      busy_q      <= busy_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign bus_id    = bus_id_q;
  assign bus_read  = bus_read_q;
  assign bus_write = bus_write_q;
  assign bus_wdata = bus_wdata_q;
  assign busy      = busy_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Self-checking bench for reg_bus_arbiter: directed scenarios plus random
// transactions checked against a transaction-level model of the arbitration rules.
module tb_reg_bus_arbiter;
  import reg_bus_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_write, req1_valid, req1_write;
  logic [15:0] req0_id, req0_wdata, req1_id, req1_wdata;
  logic        ack0, ack1;
  logic [15:0] rdata0, rdata1;
  logic [15:0] bus_id, bus_wdata, bus_rdata;
  logic        bus_read, bus_write, bus_ready, busy, err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_grant = 1;
  int last_start = 0;

  reg_bus_arbiter #(.DW(16), .IW(16), .IDLE_ID(16'h0000), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_id(req0_id),
    .req0_wdata(req0_wdata), .ack0(ack0), .rdata0(rdata0),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_id(req1_id),
    .req1_wdata(req1_wdata), .ack1(ack1), .rdata1(rdata1),
    .bus_id(bus_id), .bus_read(bus_read), .bus_write(bus_write),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Arbitration rule: lone requester wins; on a tie the port not served last wins.
  function automatic int model_winner(input logic v0, input logic v1);
    if (v0 && v1) return (last_grant == 0) ? 1 : 0;
    return v1 ? 1 : 0;
  endfunction

  task automatic run_txn(input logic v0, input logic w0, input logic [15:0] id0,
                         input logic [15:0] wd0, input logic v1, input logic w1,
                         input logic [15:0] id1, input logic [15:0] wd1,
                         input int delay, input logic [15:0] rd, input bit hold,
                         input bit chk_int, output int gp);
    int p, start;
    logic w;
    logic [15:0] id, wd, exp_rd;
    p  = model_winner(v0, v1);
    w  = p ? w1 : w0;
    id = p ? id1 : id0;
    wd = p ? wd1 : wd0;
    exp_rd = w ? 16'h0000 : rd;
    gp = p;
    req0_valid = v0; req0_write = w0; req0_id = id0; req0_wdata = wd0;
    req1_valid = v1; req1_write = w1; req1_id = id1; req1_wdata = wd1;
    bus_ready = 1'b0;
    bus_rdata = rd;
    tick();
    start = cyc;
    if (chk_int) check("interval", 32'(start - last_start), 32'd3);
    last_start = start;
    check("acc_busy", {31'd0, busy}, 32'd1);
    check("acc_id", {16'd0, bus_id}, {16'd0, id});
    check("acc_write", {31'd0, bus_write}, {31'd0, w});
    check("acc_wdata", {16'd0, bus_wdata}, w ? {16'd0, wd} : 32'd0);
    for (int k = 0; k <= delay; k++) begin
      bus_ready = (k == delay);
      check("acc_read", {31'd0, bus_read}, {31'd0, ~w});
      if (k > 0) check("write_one_pulse", {31'd0, bus_write}, 32'd0);
      check("no_early_ack", {30'd0, ack1, ack0}, 32'd0);
      tick();
    end
    bus_ready = 1'b0;
    if (!hold) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    check("ack_latency", 32'(cyc - start), 32'(delay + 1));
    check("ack0", {31'd0, ack0}, (p == 0) ? 32'd1 : 32'd0);
    check("ack1", {31'd0, ack1}, (p == 1) ? 32'd1 : 32'd0);
    check("rdata0", {16'd0, rdata0}, (p == 0) ? {16'd0, exp_rd} : 32'd0);
    check("rdata1", {16'd0, rdata1}, (p == 1) ? {16'd0, exp_rd} : 32'd0);
    check("resp_bus_idle", {bus_id, 13'd0, bus_read, bus_write, err}, 32'd0);
    last_grant = p;
    tick();
    check("idle_quiet", {29'd0, busy, ack1, ack0}, 32'd0);
  endtask

  initial begin
    int gp;
    logic [1:0] vs;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_write = 1'b0; req0_id = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_id = '0; req1_wdata = '0;
    bus_ready = 1'b0; bus_rdata = '0;
    tick(); tick();
    check("rst_outs", {ack0, ack1, bus_read, bus_write, busy, err}, 32'd0);
    check("rst_bus", {bus_id, bus_wdata}, 32'd0);
    check("rst_rdata", {rdata0, rdata1}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Port 0 read of UART data, immediate ready.
    run_txn(1, 0, ID_UART_DATA, 16'h0, 0, 0, 16'h0, 16'h0, 0, 16'h00A5, 0, 0, gp);
    check("t1_port", 32'(gp), 32'd0);
    // Port 1 write to I2C data.
    run_txn(0, 0, 16'h0, 16'h0, 1, 1, ID_I2C_DATA, 16'h1234, 0, 16'hBEEF, 0, 0, gp);
    check("t2_port", 32'(gp), 32'd1);

    // Both ports hold valid across four back-to-back accesses.
    for (int i = 0; i < 4; i++) begin
      run_txn(1, 0, ID_TXCOUNT, 16'h0, 1, 1, ID_SYNC, 16'h0F0F, 0,
              16'(16'h1000 + i), 1, i > 0, gp);
      check("b2b_alternate", 32'(gp), 32'(i % 2));
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // Five wait cycles on a read.
    run_txn(1, 0, ID_RXCOUNT, 16'h0, 0, 0, 16'h0, 16'h0, 5, 16'h5A5A, 0, 0, gp);

    // Reset mid-access aborts and restores port 0 priority.
    req0_valid = 1'b1; req0_write = 1'b0; req0_id = ID_BUSY; bus_ready = 1'b0;
    tick();
    check("rst_pre_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0; req0_valid = 1'b0;
    tick();
    check("rst_mid_outs", {ack0, ack1, bus_read, bus_write, busy, err}, 32'd0);
    check("rst_mid_bus", {bus_id, bus_wdata}, 32'd0);
    rst_n = 1'b1;
    last_grant = 1;
    tick();
    check("rst_no_ack", {30'd0, ack1, ack0}, 32'd0);
    run_txn(1, 1, ID_I2C_STATUS, 16'h0077, 1, 0, ID_BUSY, 16'h0, 1, 16'h0, 0, 0, gp);
    check("rst_tie_port0", 32'(gp), 32'd0);

    // Peripheral never answers.
    req1_valid = 1'b0; req0_valid = 1'b1; req0_write = 1'b0; req0_id = ID_SYNC;
    bus_ready = 1'b0;
    tick();
    req0_valid = 1'b0;
`ifdef REG_BUS_TIMEOUT_EN
    for (int k = 0; k < 4; k++) begin
      check("to_wait_read", {31'd0, bus_read}, 32'd1);
      tick();
    end
    check("to_ack0", {30'd0, ack1, ack0}, 32'd1);
    check("to_rdata", {16'd0, rdata0}, {16'd0, DEAD_DATA});
    check("to_err", {31'd0, err}, 32'd1);
    tick();
    check("to_idle", {29'd0, busy, err, ack0}, 32'd0);
    last_grant = 0;
`else
    for (int k = 0; k < 20; k++) tick();
    check("stuck_busy", {29'd0, busy, bus_read, ack0}, 32'b110);
    check("stuck_err", {31'd0, err}, 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    last_grant = 1;
    tick();
`endif

    // Random traffic.
    for (int i = 0; i < 30; i++) begin
      vs = 2'($urandom_range(1, 3));
      run_txn(vs[0], 1'($urandom), 16'($urandom_range(1, 9)), 16'($urandom),
              vs[1], 1'($urandom), 16'($urandom_range(1, 9)), 16'($urandom),
              $urandom_range(0, 3), 16'($urandom), 0, 0, gp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
